place_piece_recv: RTL

PLACE_PIECE_RECV -- requirements
Module: place_piece_recv

---
 rtl/place_piece_recv_pkg.sv | 38 +++
 rtl/place_piece_recv_shape_rom.sv | 45 ++++
 rtl/place_piece_recv.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/place_piece_recv_pkg.sv
// Shared definitions for the piece placement receiver: board geometry,
// piece encodings, FSM states and the cell bounds helper.
package place_piece_recv_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef enum logic [2:0] {
        PIECE_I   = 3'd0,
        PIECE_O   = 3'd1,
        PIECE_T   = 3'd2,
        PIECE_S   = 3'd3,
        PIECE_Z   = 3'd4,
        PIECE_J   = 3'd5,
        PIECE_L   = 3'd6,
        PIECE_BAD = 3'd7
    } piece_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_PLACED    = 2'd0,
        RES_COLLISION = 2'd1,
        RES_TYPE_ERR  = 2'd2
    } result_t;

    // Cell coordinates are carried at 6 bits so anchor+offset never wraps.
    function automatic logic cellOob(input logic [5:0] i, input logic [5:0] j);
        return (i > 6'(BOARD_ROWS - 1)) || (j > 6'(BOARD_COLS - 1));
    endfunction

endpackage

// File: rtl/place_piece_recv_shape_rom.sv
// Combinational shape table: returns the (row, column) offset of cell k
// of a tetromino relative to its spawn anchor.
module piece_shape_rom
    import place_piece_recv_pkg::*;
(
    input  logic [2:0] i_pieceType,
    input  logic [1:0] i_k,
    output logic [1:0] o_di,
    output logic [1:0] o_dj
);

    // Each nibble is {di, dj} for one cell; cell 0 sits in the low nibble.
    localparam logic [15:0] SHAPE_I = 16'h3210;
    localparam logic [15:0] SHAPE_O = 16'h5410;
    localparam logic [15:0] SHAPE_T = 16'h5210;
    localparam logic [15:0] SHAPE_S = 16'h5421;
    localparam logic [15:0] SHAPE_Z = 16'h6510;
    localparam logic [15:0] SHAPE_J = 16'h6540;
    localparam logic [15:0] SHAPE_L = 16'h6542;

    piece_t      w_type;
    logic [15:0] w_pack;
    logic [3:0]  w_cell;

    assign w_type = piece_t'(i_pieceType);

    always_comb begin
        w_pack = 16'h0000;
        case (w_type)
            PIECE_I: w_pack = SHAPE_I;
            PIECE_O: w_pack = SHAPE_O;
            PIECE_T: w_pack = SHAPE_T;
            PIECE_S: w_pack = SHAPE_S;
            PIECE_Z: w_pack = SHAPE_Z;
            PIECE_J: w_pack = SHAPE_J;
            PIECE_L: w_pack = SHAPE_L;
            default: w_pack = 16'h0000;
        endcase
    end

    assign w_cell = w_pack[{i_k, 2'b00} +: 4];
    assign o_di   = w_cell[3:2];
    assign o_dj   = w_cell[1:0];

endmodule

// File: rtl/place_piece_recv.sv
// Receives a spawned piece, checks its four cells against the board and
// either writes them or reports a collision / invalid type.
module place_piece_recv
    import place_piece_recv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       piece_valid,
    input  logic [4:0] pos_i,
    input  logic [4:0] pos_j,
    input  logic [2:0] piece_type,
    output logic [4:0] board_rd_i,
    output logic [4:0] board_rd_j,
    input  logic       board_rd_occ,
    output logic       board_we,
    output logic [4:0] board_wr_i,
    output logic [4:0] board_wr_j,
    output logic [2:0] board_wr_type,
    output logic       busy,
    output logic       placed,
    output logic       collision,
    output logic       type_err
);

    state_t     r_state;
    state_t     w_stateNext;
    logic [4:0] r_posI;
    logic [4:0] r_posJ;
    logic [2:0] r_type;
    logic [1:0] r_k;
    logic       r_pend;
    logic       r_pendOob;
    logic       r_blocked;
    result_t    r_result;

    logic [1:0] w_di;
    logic [1:0] w_dj;
    logic [5:0] w_cellI;
    logic [5:0] w_cellJ;
    logic       w_oob;
    logic       w_blockedNext;
    logic       w_typeBad;

    piece_shape_rom u_shapeRom (
        .i_pieceType (r_type),
        .i_k         (r_k),
        .o_di        (w_di),
        .o_dj        (w_dj)
    );

    assign w_cellI   = {1'b0, r_posI} + {4'b0000, w_di};
    assign w_cellJ   = {1'b0, r_posJ} + {4'b0000, w_dj};
    assign w_oob     = cellOob(w_cellI, w_cellJ);
    assign w_typeBad = (piece_t'(piece_type) == PIECE_BAD);

    // Occupancy lags its address by a cycle, so the bounds flag of the cell
    // just read is held in r_pendOob and merged when its sample arrives.
    assign w_blockedNext = r_blocked | (r_pend & (board_rd_occ | r_pendOob));

    assign board_wr_type = r_type;

    always_comb begin
        w_stateNext = r_state;
        board_rd_i  = 5'd0;
        board_rd_j  = 5'd0;
        board_we    = 1'b0;
        board_wr_i  = 5'd0;
        board_wr_j  = 5'd0;
        busy        = (r_state != ST_IDLE);
        placed      = 1'b0;
        collision   = 1'b0;
        type_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (piece_valid) begin
                    w_stateNext = w_typeBad ? ST_REPORT : ST_READ;
                end
            end
            ST_READ: begin
                board_rd_i = w_cellI[4:0];
                board_rd_j = w_cellJ[4:0];
                if (r_k == 2'd3) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stateNext = w_blockedNext ? ST_REPORT : ST_WRITE;
            end
            ST_WRITE: begin
                board_we   = ~w_oob;
                board_wr_i = w_cellI[4:0];
                board_wr_j = w_cellJ[4:0];
                if (r_k == 2'd3) begin
                    w_stateNext = ST_REPORT;
                end
            end
            ST_REPORT: begin
                placed      = (r_result == RES_PLACED);
                collision   = (r_result == RES_COLLISION);
                type_err    = (r_result == RES_TYPE_ERR);
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_posI    <= 5'd0;
            r_posJ    <= 5'd0;
            r_type    <= 3'd0;
            r_k       <= 2'd0;
            r_pend    <= 1'b0;
            r_pendOob <= 1'b0;
            r_blocked <= 1'b0;
            r_result  <= RES_PLACED;
        end else begin
            r_state   <= w_stateNext;
            r_pend    <= (r_state == ST_READ);
            r_pendOob <= w_oob;
            case (r_state)
                ST_IDLE: begin
                    if (piece_valid) begin
                        r_posI    <= pos_i;
                        r_posJ    <= pos_j;
                        r_type    <= piece_type;
                        r_k       <= 2'd0;
                        r_blocked <= 1'b0;
                        r_result  <= w_typeBad ? RES_TYPE_ERR : RES_PLACED;
                    end
                end
                ST_READ: begin
                    r_k       <= r_k + 2'd1;
                    r_blocked <= w_blockedNext;
                end
                ST_WAIT: begin
                    r_k       <= 2'd0;
                    r_blocked <= w_blockedNext;
                    if (w_blockedNext) begin
                        r_result <= RES_COLLISION;
                    end
                end
                ST_WRITE: begin
                    r_k <= r_k + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
